// File: rtl/key_debounce_if.sv
// Key pin and debounced outputs shared by the board/bench (master) and the debouncer (slave).
interface key_debounce_if;
  logic key;
  logic key_state;
  logic key_flag;
  logic key_rls;
  logic key_long;

  modport master (
    output key,
    input  key_state,
    input  key_flag,
    input  key_rls,
    input  key_long
  );

  modport slave (
    input  key,
    output key_state,
    output key_flag,
    output key_rls,
    output key_long
  );
endinterface

// File: rtl/key_debounce.sv
// Push-button debouncer: 2-FF sync, four-state filter FSM, level plus press/release strobes.
// Define KEY_LONG_PRESS_EN to add the one-shot long-press pulse on key_long.
module key_debounce #(
  parameter int   CNT_MAX  = 999_999,
  parameter logic KEY_ACT  = 1'b0,
  parameter int   LONG_MAX = 49_999_999
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  key_debounce_if.slave  bus
);

  localparam int CW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    P_FILT  = 2'd1,
    PRESSED = 2'd2,
    R_FILT  = 2'd3
  } state_t;

  state_t        r_fsm;
  logic [CW-1:0] r_cnt;
  logic          r_sync0;
  logic          r_sync1;
  logic          r_state;
  logic          r_flag;
  logic          r_rls;
  logic          w_ks;
  logic          w_accept_press;

  // Idle level is ~KEY_ACT so a reset release never looks like a fresh press edge.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_sync0 <= ~KEY_ACT;
      r_sync1 <= ~KEY_ACT;
    end else begin
      r_sync0 <= bus.key;
      r_sync1 <= r_sync0;
    end
  end

  assign w_ks           = (r_sync1 == KEY_ACT);
  assign w_accept_press = (r_fsm == P_FILT) && w_ks && (r_cnt == CNT_LAST);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_fsm   <= IDLE;
      r_cnt   <= '0;
      r_state <= 1'b0;
      r_flag  <= 1'b0;
      r_rls   <= 1'b0;
    end else begin
      r_flag <= 1'b0;
      r_rls  <= 1'b0;
      case (r_fsm)
        IDLE: begin
          if (w_ks) begin
            r_fsm <= P_FILT;
            r_cnt <= '0;
          end
        end
        P_FILT: begin
          if (!w_ks) begin
            r_fsm <= IDLE;
            r_cnt <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_fsm   <= PRESSED;
            r_flag  <= 1'b1;
            r_state <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!w_ks) begin
            r_fsm <= R_FILT;
            r_cnt <= '0;
          end
        end
        R_FILT: begin
          if (w_ks) begin
            r_fsm <= PRESSED;
            r_cnt <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_fsm   <= IDLE;
            r_rls   <= 1'b1;
            r_state <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_fsm <= IDLE;
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.key_state = r_state;
  assign bus.key_flag  = r_flag;
  assign bus.key_rls   = r_rls;

`ifdef KEY_LONG_PRESS_EN
  localparam int LW = (LONG_MAX > 0) ? $clog2(LONG_MAX + 1) : 1;
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_MAX);

  logic [LW-1:0] r_lcnt;
  logic          r_long_done;
  logic          r_long;

  // Held-time counter survives release bounces; r_long_done limits it to one pulse per press.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_lcnt      <= '0;
      r_long_done <= 1'b0;
      r_long      <= 1'b0;
    end else begin
      r_long <= 1'b0;
      if (w_accept_press || (r_fsm == IDLE)) begin
        r_lcnt      <= '0;
        r_long_done <= 1'b0;
      end else if ((r_fsm == PRESSED) || (r_fsm == R_FILT)) begin
        if (r_lcnt == LONG_LAST) begin
          if (!r_long_done) begin
            r_long      <= 1'b1;
            r_long_done <= 1'b1;
          end
        end else begin
          r_lcnt <= r_lcnt + 1'b1;
        end
      end
    end
  end

  assign bus.key_long = r_long;
`else
  // Always 0 for legal LONG_MAX; the comparison keeps the parameter referenced.
  assign bus.key_long = (LONG_MAX < 0);
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with CNT_MAX=9, LONG_MAX=49, KEY_ACT=0 and a 20 ns clock.
module tb_key_debounce;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;

  key_debounce_if kif ();

  key_debounce #(
    .CNT_MAX  (9),
    .KEY_ACT  (1'b0),
    .LONG_MAX (49)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (kif.slave)
  );

  always #10 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int flagCount, rlsCount, longCount, bothCount;
  int flagCyc, rlsCyc, longCyc;
  int mark;
  logic expLong;

  task automatic clearMon();
    flagCount = 0;
    rlsCount  = 0;
    longCount = 0;
    bothCount = 0;
    flagCyc   = -1;
    rlsCyc    = -1;
    longCyc   = -1;
  endtask

  // Drive key at a falling edge, then watch the strobes for n sampling points.
  task automatic applyStimulus(input logic keyVal, input int n);
    kif.key = keyVal;
    repeat (n) begin
      @(negedge sys_clk);
      cyc++;
      if (kif.key_flag === 1'b1) begin
        flagCount++;
        flagCyc = cyc;
      end
      if (kif.key_rls === 1'b1) begin
        rlsCount++;
        rlsCyc = cyc;
      end
      if (kif.key_long === 1'b1) begin
        longCount++;
        longCyc = cyc;
      end
      if ((kif.key_flag === 1'b1) && (kif.key_rls === 1'b1)) bothCount++;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef KEY_LONG_PRESS_EN
    expLong = 1'b1;
`else
    expLong = 1'b0;
`endif
    kif.key = 1'b0;
    clearMon();
    @(negedge sys_clk);

    // Reset held with the key pressed
    applyStimulus(1'b0, 4);
    checkOutput("rst_state", 32'(kif.key_state), 0);
    checkOutput("rst_flag",  32'(kif.key_flag),  0);
    checkOutput("rst_rls",   32'(kif.key_rls),   0);
    checkOutput("rst_long",  32'(kif.key_long),  0);
    checkOutput("rst_no_strobe", 32'(flagCount + rlsCount), 0);

    // Release reset with the key still held: press qualified 13 cycles later
    sys_rst = 1'b0;
    mark = cyc;
    clearMon();
    applyStimulus(1'b0, 20);
    checkOutput("t1_flag_count", 32'(flagCount), 1);
    checkOutput("t1_flag_lat",   32'(flagCyc - mark), 13);
    checkOutput("t1_state",      32'(kif.key_state), 1);
    mark = cyc;
    clearMon();
    applyStimulus(1'b1, 20);
    checkOutput("t1_rls_count", 32'(rlsCount), 1);
    checkOutput("t1_rls_lat",   32'(rlsCyc - mark), 13);
    checkOutput("t1_state_rel", 32'(kif.key_state), 0);

    // Bouncing press never stays stable long enough
    clearMon();
    applyStimulus(1'b0, 5);
    applyStimulus(1'b1, 2);
    applyStimulus(1'b0, 5);
    applyStimulus(1'b1, 20);
    checkOutput("t2_no_flag", 32'(flagCount), 0);
    checkOutput("t2_state",   32'(kif.key_state), 0);

    // Clean 30-cycle press then release
    mark = cyc;
    clearMon();
    applyStimulus(1'b0, 30);
    checkOutput("t3_flag_count", 32'(flagCount), 1);
    checkOutput("t3_flag_lat",   32'(flagCyc - mark), 13);
    checkOutput("t3_state_held", 32'(kif.key_state), 1);
    mark = cyc;
    applyStimulus(1'b1, 20);
    checkOutput("t3_rls_count", 32'(rlsCount), 1);
    checkOutput("t3_rls_lat",   32'(rlsCyc - mark), 13);
    checkOutput("t3_state_rel", 32'(kif.key_state), 0);
    checkOutput("t3_no_both",   32'(bothCount), 0);

    // 3-cycle release glitch while pressed
    applyStimulus(1'b0, 20);
    checkOutput("t4_pressed", 32'(kif.key_state), 1);
    clearMon();
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 20);
    checkOutput("t4_no_rls", 32'(rlsCount), 0);
    checkOutput("t4_state",  32'(kif.key_state), 1);
    mark = cyc;
    applyStimulus(1'b1, 20);
    checkOutput("t4_rls_count", 32'(rlsCount), 1);
    checkOutput("t4_rls_lat",   32'(rlsCyc - mark), 13);

    // Reset pulse in the middle of the press filter, key then released
    clearMon();
    applyStimulus(1'b0, 8);
    sys_rst = 1'b1;
    applyStimulus(1'b1, 2);
    checkOutput("t5_rst_state", 32'(kif.key_state), 0);
    checkOutput("t5_rst_flag",  32'(kif.key_flag),  0);
    sys_rst = 1'b0;
    applyStimulus(1'b1, 25);
    checkOutput("t5_no_flag", 32'(flagCount), 0);
    checkOutput("t5_state",   32'(kif.key_state), 0);

    // Reset mid-filter with key held: press re-qualified from scratch
    applyStimulus(1'b0, 8);
    sys_rst = 1'b1;
    applyStimulus(1'b0, 2);
    sys_rst = 1'b0;
    mark = cyc;
    clearMon();
    applyStimulus(1'b0, 20);
    checkOutput("t5b_flag_count", 32'(flagCount), 1);
    checkOutput("t5b_flag_lat",   32'(flagCyc - mark), 13);
    applyStimulus(1'b1, 20);
    checkOutput("t5b_state_rel", 32'(kif.key_state), 0);

    // 100-cycle hold: one long pulse 50 cycles after the press strobe when enabled
    mark = cyc;
    clearMon();
    applyStimulus(1'b0, 100);
    checkOutput("t6_flag_count", 32'(flagCount), 1);
    checkOutput("t6_long_count", 32'(longCount), 32'(expLong));
    if (expLong) checkOutput("t6_long_lat", 32'(longCyc - flagCyc), 50);
    applyStimulus(1'b1, 20);
    checkOutput("t6_long_after_rel", 32'(longCount), 32'(expLong));
    checkOutput("t6_state", 32'(kif.key_state), 0);
    checkOutput("t6_rls_count", 32'(rlsCount), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
